// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial line, frame configuration and received-byte outputs of uart_rx.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 6
);
  logic                  RX_IN;
  logic [CNT_WIDTH-1:0]  PRESCALE;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_ERR;
  logic                  STP_ERR;

  modport master (
    output RX_IN, PRESCALE, PAR_EN, PAR_TYP,
    input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR
  );

  modport slave (
    input  RX_IN, PRESCALE, PAR_EN, PAR_TYP,
    output P_DATA, DATA_VALID, PAR_ERR, STP_ERR
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter plus three-tap mid-bit capture and 2-of-3 vote.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int CNT_WIDTH = 6
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic                 i_rx,
  input  logic [CNT_WIDTH-1:0] i_prescale,
  output logic [CNT_WIDTH-1:0] o_edge_cnt,
  output logic                 o_bit_done,
  output logic                 o_sampled_bit
);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic [2:0]           r_tap;
  logic [CNT_WIDTH-1:0] w_half;
  logic [CNT_WIDTH-1:0] w_last;

  assign w_half = i_prescale >> 1;
  assign w_last = i_prescale - 1'b1;

  assign o_edge_cnt    = r_cnt;
  assign o_bit_done    = i_en && (r_cnt == w_last);
  assign o_sampled_bit = majority3(r_tap);

  // Counter stays at 0 while disabled so the detect cycle is edge 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_tap <= 3'b111;
    end else if (!i_en) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= o_bit_done ? '0 : r_cnt + 1'b1;
      if (r_cnt == w_half - 1'b1) r_tap[0] <= i_rx;
      if (r_cnt == w_half)        r_tap[1] <= i_rx;
      if (r_cnt == w_half + 1'b1) r_tap[2] <= i_rx;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART frame decoder: start/data/parity/stop FSM, shift register and checks.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 6
) (
  input  logic    CLK,
  input  logic    RST,
  uart_rx_if.slave bus
);

  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  rx_state_t             r_state;
  logic [BW-1:0]         r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_par_err;
  logic [DATA_WIDTH-1:0] r_p_data;
  logic                  r_data_valid;
  logic                  r_par_err_o;
  logic                  r_stp_err_o;

  logic                  w_en;
  logic                  w_detect;
  logic [CNT_WIDTH-1:0]  w_edge_cnt;
  logic                  w_bit_done;
  logic                  w_sampled;
  logic                  w_par_exp;

  // Detect cycle is edge 0 of the start bit, so the counter runs from it.
  assign w_detect  = (r_state == ST_IDLE) && (w_edge_cnt == '0) && !bus.RX_IN;
  assign w_en      = (r_state != ST_IDLE) || w_detect;
  assign w_par_exp = (^r_shift) ^ (r_par_typ == PAR_ODD);

  uart_rx_sampler #(.CNT_WIDTH(CNT_WIDTH)) u_sampler (
    .i_clk        (CLK),
    .i_rst        (RST),
    .i_en         (w_en),
    .i_rx         (bus.RX_IN),
    .i_prescale   (bus.PRESCALE),
    .o_edge_cnt   (w_edge_cnt),
    .o_bit_done   (w_bit_done),
    .o_sampled_bit(w_sampled)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par_en     <= 1'b0;
      r_par_typ    <= 1'b0;
      r_par_err    <= 1'b0;
      r_p_data     <= '0;
      r_data_valid <= 1'b0;
      r_par_err_o  <= 1'b0;
      r_stp_err_o  <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_par_err_o  <= 1'b0;
      r_stp_err_o  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_bit_cnt <= '0;
          if (w_detect) begin
            r_state   <= ST_START;
            r_par_en  <= bus.PAR_EN;
            r_par_typ <= bus.PAR_TYP;
            r_par_err <= 1'b0;
          end
        end
        ST_START: begin
          if (w_bit_done) r_state <= w_sampled ? ST_IDLE : ST_DATA;
        end
        ST_DATA: begin
          if (w_bit_done) begin
            r_shift <= {w_sampled, r_shift[DATA_WIDTH-1:1]};
            if (r_bit_cnt == LAST_BIT) begin
              r_bit_cnt <= '0;
              r_state   <= r_par_en ? ST_PARITY : ST_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (w_bit_done) begin
            r_par_err <= (w_sampled != w_par_exp);
            r_state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          // Outputs land on the first cycle back in IDLE (t = F).
          if (w_bit_done) begin
            r_state <= ST_IDLE;
            if (r_par_err || !w_sampled) begin
              r_par_err_o <= r_par_err;
              r_stp_err_o <= !w_sampled;
            end else begin
              r_p_data     <= r_shift;
              r_data_valid <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.P_DATA     = r_p_data;
  assign bus.DATA_VALID = r_data_valid;
  assign bus.PAR_ERR    = r_par_err_o;
  assign bus.STP_ERR    = r_stp_err_o;

endmodule

// File: tb/tb_uart_rx.sv
// Directed frames against a frame-level receive model, checked every cycle.
module tb_uart_rx;
  import uart_rx_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  uart_rx_if #(.DATA_WIDTH(8), .CNT_WIDTH(6)) bus ();
  uart_rx #(.DATA_WIDTH(8), .CNT_WIDTH(6)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  int n_chk = 0;
  int n_pass = 0;

  bit         wave[$];
  bit         e_dv[$], e_pe[$], e_se[$];
  logic [7:0] e_pd[$], ev_d[$];
  logic [7:0] m_pdata = 8'h00;
  int         idx = 0;
  bit         live = 1'b0;
  int         dv_q[$], pe_q[$], se_q[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Single compare process: every cycle of a played wave.
  always @(negedge CLK) begin
    if (live) begin
      chk($sformatf("dv@%0d", idx), 32'(bus.DATA_VALID), 32'(e_dv[idx]));
      chk($sformatf("pe@%0d", idx), 32'(bus.PAR_ERR),    32'(e_pe[idx]));
      chk($sformatf("se@%0d", idx), 32'(bus.STP_ERR),    32'(e_se[idx]));
      chk($sformatf("pd@%0d", idx), 32'(bus.P_DATA),     32'(e_pd[idx]));
      if (bus.DATA_VALID) dv_q.push_back(idx);
      if (bus.PAR_ERR)    pe_q.push_back(idx);
      if (bus.STP_ERR)    se_q.push_back(idx);
    end
  end

  function automatic bit smp(int t);
    return (t < wave.size()) ? wave[t] : 1'b1;
  endfunction

  function automatic bit vote(int t0, int k, int p);
    int c = t0 + k * p + p / 2;
    int s = int'(smp(c - 1)) + int'(smp(c)) + int'(smp(c + 1));
    return s >= 2;
  endfunction

  // Walk the line: find falling starts, vote each bit, place the result at t0+F.
  task automatic build_model(int p, bit pe, bit pt);
    int n = wave.size();
    int t = 0;
    int nb, te;
    logic [7:0] d;
    bit pbit, stp, perr, serr;
    e_dv.delete(); e_pe.delete(); e_se.delete(); e_pd.delete(); ev_d.delete();
    for (int i = 0; i < n; i++) begin
      e_dv.push_back(0); e_pe.push_back(0); e_se.push_back(0);
      e_pd.push_back(8'h00); ev_d.push_back(8'h00);
    end
    while (t < n) begin
      if (wave[t]) begin t++; continue; end
      if (vote(t, 0, p)) begin t += p; continue; end
      for (int k = 0; k < 8; k++) d[k] = vote(t, k + 1, p);
      nb   = pe ? 11 : 10;
      pbit = vote(t, 9, p);
      stp  = vote(t, nb - 1, p);
      perr = pe && (pbit != ((^d) ^ pt));
      serr = !stp;
      te   = t + nb * p;
      if (te < n) begin
        if (perr || serr) begin e_pe[te] = perr; e_se[te] = serr; end
        else begin e_dv[te] = 1'b1; ev_d[te] = d; end
      end
      t = te;
    end
    for (int i = 0; i < n; i++) begin
      if (e_dv[i]) m_pdata = ev_d[i];
      e_pd[i] = m_pdata;
    end
  endtask

  task automatic lvl(bit b, int n);
    repeat (n) wave.push_back(b);
  endtask

  task automatic frame(logic [7:0] d, int p, bit has_par, bit pbit, bit stop);
    lvl(1'b0, p);
    for (int k = 0; k < 8; k++) lvl(d[k], p);
    if (has_par) lvl(pbit, p);
    lvl(stop, p);
  endtask

  task automatic play(int p, bit pe, bit pt);
    bus.PRESCALE = 6'(p);
    bus.PAR_EN   = pe;
    bus.PAR_TYP  = pt;
    build_model(p, pe, pt);
    dv_q.delete(); pe_q.delete(); se_q.delete();
    for (int i = 0; i < wave.size(); i++) begin
      @(posedge CLK); #1;
      bus.RX_IN = wave[i];
      idx = i;
      live = 1'b1;
    end
    @(posedge CLK); #1;
    live = 1'b0;
    bus.RX_IN = 1'b1;
  endtask

  function automatic int first(int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  initial begin
    bus.RX_IN = 1'b1; bus.PRESCALE = 6'd8; bus.PAR_EN = 1'b0; bus.PAR_TYP = PAR_EVEN;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_dv", 32'(bus.DATA_VALID), 0);
    chk("rst_pe", 32'(bus.PAR_ERR), 0);
    chk("rst_se", 32'(bus.STP_ERR), 0);
    chk("rst_pd", 32'(bus.P_DATA), 0);
    RST = 1'b0;

    // P=8, no parity, 0xA5
    wave.delete(); lvl(1, 4); frame(8'hA5, 8, 0, 0, 1); lvl(1, 6);
    play(PRESCALE_8, 0, PAR_EVEN);
    chk("t1_dv_cnt", dv_q.size(), 1);
    chk("t1_dv_t", first(dv_q), 84);
    chk("t1_pd", 32'(bus.P_DATA), 32'hA5);

    // P=16, even parity, correct
    wave.delete(); lvl(1, 4); frame(8'h3C, 16, 1, 0, 1); lvl(1, 6);
    play(PRESCALE_16, 1, PAR_EVEN);
    chk("t2_dv_t", first(dv_q), 180);
    chk("t2_pd", 32'(bus.P_DATA), 32'h3C);

    // same line, odd parity expected -> parity error
    play(PRESCALE_16, 1, PAR_ODD);
    chk("t2b_pe_t", first(pe_q), 180);
    chk("t2b_dv_cnt", dv_q.size(), 0);
    chk("t2b_pd", 32'(bus.P_DATA), 32'h3C);

    // bad stop
    wave.delete(); lvl(1, 4); frame(8'h5A, 8, 0, 0, 0); lvl(1, 6);
    play(PRESCALE_8, 0, PAR_EVEN);
    chk("t3_se_t", first(se_q), 84);
    chk("t3_dv_cnt", dv_q.size(), 0);
    chk("t3_pd", 32'(bus.P_DATA), 32'h3C);

    // glitch then back-to-back 0x01, 0xFF
    wave.delete(); lvl(1, 4); lvl(0, 3); lvl(1, 20);
    frame(8'h01, 16, 0, 0, 1); frame(8'hFF, 16, 0, 0, 1); lvl(1, 6);
    play(PRESCALE_16, 0, PAR_EVEN);
    chk("t4_dv_cnt", dv_q.size(), 2);
    chk("t4_dv_t", first(dv_q), 187);
    chk("t4_gap", (dv_q.size() == 2) ? dv_q[1] - dv_q[0] : -1, 160);
    chk("t4_err_cnt", pe_q.size() + se_q.size(), 0);
    chk("t4_pd", 32'(bus.P_DATA), 32'hFF);

    // centre-tap glitch on data bit 3 of 0xFF
    wave.delete(); lvl(1, 4); frame(8'hFF, 8, 0, 0, 1); lvl(1, 6);
    wave[40] = 1'b0;
    play(PRESCALE_8, 0, PAR_EVEN);
    chk("t5_dv_t", first(dv_q), 84);
    chk("t5_pd", 32'(bus.P_DATA), 32'hFF);

    // break: stop error, immediate re-detect, then 0xFE
    wave.delete(); lvl(1, 4); lvl(0, 100); lvl(1, 100);
    play(PRESCALE_8, 0, PAR_EVEN);
    chk("t6_se_t", first(se_q), 84);
    chk("t6_dv_t", first(dv_q), 164);
    chk("t6_pd", 32'(bus.P_DATA), 32'hFE);

    // reset mid-frame, then clean 0x81
    bus.PRESCALE = 6'd8;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK); #1;
      bus.RX_IN = (i < 8) ? 1'b0 : 1'b1;
    end
    @(posedge CLK); #3;
    RST = 1'b1;
    #1;
    chk("t7_rst_pd", 32'(bus.P_DATA), 0);
    chk("t7_rst_dv", 32'(bus.DATA_VALID), 0);
    chk("t7_rst_err", 32'({bus.PAR_ERR, bus.STP_ERR}), 0);
    bus.RX_IN = 1'b1;
    @(posedge CLK); @(posedge CLK); #3;
    RST = 1'b0;
    m_pdata = 8'h00;
    wave.delete(); lvl(1, 4); frame(8'h81, 8, 0, 0, 1); lvl(1, 6);
    play(PRESCALE_8, 0, PAR_EVEN);
    chk("t7_dv_t", first(dv_q), 84);
    chk("t7_pd", 32'(bus.P_DATA), 32'h81);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
